// File: rtl/rv_mem_pkg.sv
// Shared constants and types for the rv_pl simulation memory model.
package rv_mem_pkg;

    localparam logic [31:0] RV_NOP        = 32'h0000_0013;
    localparam logic [31:0] RV_DONE_ADDR  = 32'h0000_2000;
    localparam logic [31:0] RV_DONE_VALUE = 32'hCAFE_BABE;
    localparam int          RD_LAT_MAX    = 4;

    // One data-port request as seen on a single clock edge.
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/rv_mem_rdpipe.sv
// Read-data delay line: LAT registered stages, async-reset to RST_VAL so a
// reset mid-read flushes every in-flight word.
module rv_mem_rdpipe #(
    parameter int          LAT     = 1,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [LAT-1:0][31:0] stage_q;
    logic [LAT-1:0][31:0] stage_d;

    // Stage 0 captures the array read; later stages just shift.
    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[LAT-1];

endmodule

// File: rtl/rv_sim_mem.sv
// IMEM/DMEM simulation model with read latency, byte-masked stores,
// out-of-range flagging and a sticky pass/fail mailbox with cycle counter.
// Macro RV_MEM_BYTE_EN: when defined dmem_be masks stores and the mailbox
// needs a full-word write; when undefined every store is full-word.
module rv_sim_mem
    import rv_mem_pkg::*;
#(
    parameter int          WORDS      = 4096,
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] DONE_ADDR  = RV_DONE_ADDR,
    parameter logic [31:0] DONE_VALUE = RV_DONE_VALUE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    input  logic        dmem_we,
    input  logic [3:0]  dmem_be,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        done,
    output logic        fail,
    output logic [31:0] fail_code,
    output logic        oob_err,
    output logic [31:0] cycles
);

    localparam int AW  = $clog2(WORDS);
    // Out-of-range latencies are clamped rather than producing a broken pipe.
    localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

    // IMEM has no write port; the bench fills it directly.
    logic [31:0] imem_mem [WORDS];
    logic [31:0] dmem_mem [WORDS];

    dmem_req_t   req;
    logic [AW-1:0] i_idx, d_idx;
    logic        i_oob, d_oob;
    logic [31:0] i_rd, d_rd;
    logic [3:0]  be_eff;
    logic        mb_be_ok, mb_hit, stop;

    logic        done_q, done_d, fail_q, fail_d, oob_q, oob_d;
    logic [31:0] fail_code_q, fail_code_d, cycles_q, cycles_d;

    assign req   = '{we: dmem_we, be: dmem_be, addr: dmem_addr, wdata: dmem_wdata};
    assign i_idx = imem_addr[AW+1:2];
    assign d_idx = req.addr[AW+1:2];
    assign i_oob = |imem_addr[31:AW+2];
    assign d_oob = |req.addr[31:AW+2];

`ifdef RV_MEM_BYTE_EN
    assign be_eff   = req.be;
    assign mb_be_ok = (req.be == 4'hF);
    logic unused_lsbs;
    assign unused_lsbs = ^imem_addr[1:0];
`else
    assign be_eff   = 4'hF;
    assign mb_be_ok = 1'b1;
    logic unused_lsbs;
    assign unused_lsbs = ^{imem_addr[1:0], req.be};
`endif

    assign mb_hit = req.we && (req.addr == DONE_ADDR) && mb_be_ok;
    assign stop   = done_q | fail_q;

    // Array reads happen before the edge, so a same-edge store is not seen.
    always_comb begin
        i_rd = i_oob ? RV_NOP : imem_mem[i_idx];
        d_rd = d_oob ? 32'h0  : dmem_mem[d_idx];
    end

    // Byte-lane stores; out-of-range stores are dropped.
    always_ff @(posedge clk) begin
        if (req.we && !d_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (be_eff[b]) dmem_mem[d_idx][8*b +: 8] <= req.wdata[8*b +: 8];
            end
        end
    end

    // Sticky status and the run counter; only the first mailbox write counts.
    always_comb begin
        done_d      = done_q;
        fail_d      = fail_q;
        fail_code_d = fail_code_q;
        oob_d       = oob_q | i_oob | d_oob;
        cycles_d    = cycles_q;
        if (!stop && cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (mb_hit && !stop) begin
            if (req.wdata == DONE_VALUE) begin
                done_d = 1'b1;
            end else begin
                fail_d      = 1'b1;
                fail_code_d = req.wdata;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= 32'h0;
            oob_q       <= 1'b0;
            cycles_q    <= 32'h0;
        end else begin
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
            oob_q       <= oob_d;
            cycles_q    <= cycles_d;
        end
    end

    rv_mem_rdpipe #(.LAT(LAT), .RST_VAL(RV_NOP)) u_ipipe (
        .clk(clk), .rst_n(rst_n), .d(i_rd), .q(imem_rdata)
    );

    rv_mem_rdpipe #(.LAT(LAT), .RST_VAL(32'h0)) u_dpipe (
        .clk(clk), .rst_n(rst_n), .d(d_rd), .q(dmem_rdata)
    );

    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign oob_err   = oob_q;
    assign cycles    = cycles_q;

endmodule
